// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone port arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    DRAIN   = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Index width for n ports; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first requester after 'last', with wrap.
module rr_priority_encoder import wb_arb_pkg::*; #(
  parameter  int N  = 3,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] winner
);

  // Walk from the farthest candidate to the nearest so the nearest overwrites.
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin Wishbone arbiter: WB_PORTS masters onto one slave port.
// A grant is held for the whole cyc (bursts, locked sequences) and is
// always followed by one dead IDLE cycle before the next arbitration.
// Optional watchdog: define WB_PORT_ARBITER_TIMEOUT_EN to abort a granted
// cycle with err after TIMEOUT unanswered stb cycles.
module wb_port_arbiter import wb_arb_pkg::*; #(
  parameter int WB_PORTS = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  input  logic [WB_PORTS*AW-1:0]   wbm_adr_i,
  input  logic [WB_PORTS*DW-1:0]   wbm_dat_i,
  input  logic [WB_PORTS*DW/8-1:0] wbm_sel_i,
  input  logic [WB_PORTS-1:0]      wbm_we_i,
  input  logic [WB_PORTS-1:0]      wbm_cyc_i,
  input  logic [WB_PORTS-1:0]      wbm_stb_i,
  input  logic [WB_PORTS*3-1:0]    wbm_cti_i,
  input  logic [WB_PORTS*2-1:0]    wbm_bte_i,
  output logic [WB_PORTS*DW-1:0]   wbm_dat_o,
  output logic [WB_PORTS-1:0]      wbm_ack_o,
  output logic [WB_PORTS-1:0]      wbm_err_o,
  output logic [AW-1:0]            wbs_adr_o,
  output logic [DW-1:0]            wbs_dat_o,
  output logic [DW/8-1:0]          wbs_sel_o,
  output logic                     wbs_we_o,
  output logic                     wbs_cyc_o,
  output logic                     wbs_stb_o,
  output logic [2:0]               wbs_cti_o,
  output logic [1:0]               wbs_bte_o,
  input  logic [DW-1:0]            wbs_dat_i,
  input  logic                     wbs_ack_i,
  input  logic                     wbs_err_i
);

  localparam int IW = idx_w(WB_PORTS);
  localparam int SW = DW / 8;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;

  logic          req_valid;
  logic [IW-1:0] req_winner;
  logic          gnt_cyc, gnt_stb;
  logic          tmo_fire;

  rr_priority_encoder #(.N(WB_PORTS)) u_rr (
    .req    (wbm_cyc_i),
    .last   (last_q),
    .valid  (req_valid),
    .winner (req_winner)
  );

  assign gnt_cyc   = wbm_cyc_i[gnt_q];
  assign gnt_stb   = wbm_stb_i[gnt_q];
  assign wbm_dat_o = {WB_PORTS{wbs_dat_i}};

`ifdef WB_PORT_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Fire on the TIMEOUT-th unanswered stb cycle of the current grant.
  assign tmo_fire = (state_q == GRANTED) && gnt_stb && !wbs_ack_i && !wbs_err_i &&
                    (cnt_q == CW'(TIMEOUT - 1));

  // Watchdog count: cleared while idle (so a fresh grant starts at 0) and on any response.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != GRANTED || wbs_ack_i || wbs_err_i) cnt_d = '0;
    else if (gnt_stb)                                 cnt_d = cnt_q + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Next-state: arbitrate only from IDLE, release when the granted cyc drops.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = GRANTED;
        gnt_d   = req_winner;
        last_d  = req_winner;
      end
      GRANTED: begin
        if (!gnt_cyc)      state_d = IDLE;
        else if (tmo_fire) state_d = DRAIN;
      end
      DRAIN: if (!gnt_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant and rotation pointer; last starts at the top so port 0 wins first.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(WB_PORTS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Slave mux and response steering; everything quiet outside GRANTED.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    if (state_q == GRANTED) begin
      wbm_ack_o[gnt_q] = wbs_ack_i;
      wbm_err_o[gnt_q] = wbs_err_i | tmo_fire;
      if (!tmo_fire) begin
        wbs_adr_o = wbm_adr_i[int'(gnt_q)*AW +: AW];
        wbs_dat_o = wbm_dat_i[int'(gnt_q)*DW +: DW];
        wbs_sel_o = wbm_sel_i[int'(gnt_q)*SW +: SW];
        wbs_we_o  = wbm_we_i[gnt_q];
        wbs_cyc_o = gnt_cyc;
        wbs_stb_o = gnt_stb;
        wbs_cti_o = wbm_cti_i[int'(gnt_q)*3 +: 3];
        wbs_bte_o = wbm_bte_i[int'(gnt_q)*2 +: 2];
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: scripted masters, scoreboards for grant order
// (by granted address) and for per-master ack steering.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [N*AW-1:0]   wbm_adr_i;
  logic [N*DW-1:0]   wbm_dat_i;
  logic [N*SW-1:0]   wbm_sel_i;
  logic [N-1:0]      wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0]    wbm_cti_i;
  logic [N*2-1:0]    wbm_bte_i;
  logic [N*DW-1:0]   wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [SW-1:0]     wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i, wbs_err_i;

  logic [AW-1:0] m_adr [N];
  logic [2:0]    m_cti [N];
  logic          m_cyc [N];
  logic          m_stb [N];

  always #5 wb_clk = ~wb_clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wbm_adr_i[i*AW +: AW] = m_adr[i];
      wbm_dat_i[i*DW +: DW] = 32'hD000_0000 | i;
      wbm_sel_i[i*SW +: SW] = '1;
      wbm_cti_i[i*3 +: 3]   = m_cti[i];
      wbm_bte_i[i*2 +: 2]   = 2'b00;
      wbm_we_i[i]           = 1'b0;
      wbm_cyc_i[i]          = m_cyc[i];
      wbm_stb_i[i]          = m_stb[i];
    end
  end

  wb_port_arbiter #(.WB_PORTS(N), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  // Scoreboards: address expected on each new wbs_cyc_o rise, ack mask on each slave ack.
  logic [AW-1:0] exp_adr_q [$];
  logic [N-1:0]  exp_ack_q [$];
  logic          prev_cyc = 1'b0;

  always @(negedge wb_clk) begin
    if (wbs_cyc_o === 1'b1 && prev_cyc !== 1'b1) begin
      if (exp_adr_q.size() == 0) chk("grant_unexpected", 64'(exp_adr_q.size()), 64'd1);
      else                       chk("grant_adr", wbs_adr_o, exp_adr_q.pop_front());
    end
    if (wbs_ack_i === 1'b1) begin
      if (exp_ack_q.size() == 0) chk("ack_unexpected", 64'(exp_ack_q.size()), 64'd1);
      else                       chk("ack_mask", wbm_ack_o, exp_ack_q.pop_front());
    end
    prev_cyc = wbs_cyc_o;
  end

  initial begin
    wb_rst = 1'b1; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_dat_i = '0;
    for (int i = 0; i < N; i++) begin
      m_adr[i] = '0; m_cti[i] = CTI_CLASSIC; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    end

    // Reset overrides requests and a slave ack.
    step();
    for (int i = 0; i < N; i++) begin m_cyc[i] = 1'b1; m_stb[i] = 1'b1; end
    wbs_ack_i = 1'b1; exp_ack_q.push_back('0);
    #2;
    chk("rst_cyc", wbs_cyc_o, 0);
    chk("rst_stb", wbs_stb_o, 0);
    chk("rst_ack", wbm_ack_o, 0);
    chk("rst_err", wbm_err_o, 0);
    step();
    wbs_ack_i = 1'b0; wb_rst = 1'b0;
    for (int i = 0; i < N; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end

    // Single master read on port 1.
    step();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h100; exp_adr_q.push_back(32'h100);
    #2 chk("t1_latency", wbs_cyc_o, 0);
    step(); #2;
    chk("t1_cyc", wbs_cyc_o, 1);
    chk("t1_adr", wbs_adr_o, 32'h100);
    step();
    step();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFE_F00D; exp_ack_q.push_back(3'b010);
    #2;
    chk("t1_ack", wbm_ack_o, 3'b010);
    chk("t1_dat", wbm_dat_o[1*DW +: DW], 32'hCAFE_F00D);
    step();
    wbs_ack_i = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #2 chk("t1_release", wbs_cyc_o, 0);

    // Stray ack in IDLE reaches nobody.
    step();
    wbs_ack_i = 1'b1; exp_ack_q.push_back('0);
    #2 chk("stray_ack", wbm_ack_o, 0);
    step();
    wbs_ack_i = 1'b0;

    // Round robin after a fresh reset: 0,1,2,0 with a dead cycle between grants.
    wb_rst = 1'b1;
    step();
    wb_rst = 1'b0;
    step();
    for (int p = 0; p < N; p++) begin
      m_cyc[p] = 1'b1; m_stb[p] = 1'b1; m_adr[p] = 32'h1000 * (p + 1);
    end
    for (int g = 0; g < 4; g++) exp_adr_q.push_back(32'h1000 * ((g % N) + 1));
    for (int g = 0; g < 4; g++) begin
      int p;
      p = g % N;
      for (int c = 0; c < 4; c++) begin
        step(); #2;
        chk($sformatf("rr%0d_hold_adr", g), wbs_adr_o, 32'h1000 * (p + 1));
        chk($sformatf("rr%0d_hold_cyc", g), wbs_cyc_o, 1);
      end
      step();
      m_cyc[p] = 1'b0; m_stb[p] = 1'b0;
      #2 chk($sformatf("rr%0d_drop", g), wbs_cyc_o, 0);
      step();
      if (g < 3) begin m_cyc[p] = 1'b1; m_stb[p] = 1'b1; end
      else for (int i = 0; i < N; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end
      #2 chk($sformatf("rr%0d_dead", g), wbs_cyc_o, 0);
    end

    // 8-beat incrementing burst on port 0; port 2 requests from beat 2.
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = CTI_INC; m_adr[0] = 32'h2000;
    exp_adr_q.push_back(32'h2000);
    step();
    for (int b = 1; b <= 8; b++) begin
      m_adr[0] = 32'h2000 + 4 * (b - 1);
      m_cti[0] = (b == 8) ? CTI_EOB : CTI_INC;
      if (b == 2) begin m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[2] = 32'h3000; end
      wbs_ack_i = 1'b1; exp_ack_q.push_back(3'b001);
      #2;
      chk($sformatf("burst_b%0d_adr", b), wbs_adr_o, 32'h2000 + 4 * (b - 1));
      chk($sformatf("burst_b%0d_cti", b), wbs_cti_o, (b == 8) ? CTI_EOB : CTI_INC);
      step();
    end
    wbs_ack_i = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = CTI_CLASSIC;
    exp_adr_q.push_back(32'h3000);
    #2 chk("burst_drop_cyc", wbs_cyc_o, 0);
    step(); #2 chk("burst_dead_cyc", wbs_cyc_o, 0);
    step();
    wbs_err_i = 1'b1;
    #2;
    chk("p2_adr", wbs_adr_o, 32'h3000);
    chk("p2_err", wbm_err_o, 3'b100);
    // Ack in the same cycle the granted cyc falls is still delivered.
    step();
    wbs_err_i = 1'b0; wbs_ack_i = 1'b1; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    exp_ack_q.push_back(3'b100);
    #2 chk("same_cycle_ack", wbm_ack_o, 3'b100);
    step();
    wbs_ack_i = 1'b0;

    // Reset during beat 3 of a port 1 burst, then port 0 wins over port 1.
    step();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = CTI_INC; m_adr[1] = 32'h4000;
    exp_adr_q.push_back(32'h4000);
    for (int b = 1; b <= 3; b++) begin
      step();
      m_adr[1] = 32'h4000 + 4 * (b - 1);
      wbs_ack_i = 1'b1; exp_ack_q.push_back(3'b010);
      if (b == 3) wb_rst = 1'b1;
    end
    step();
    wb_rst = 1'b0; exp_ack_q.push_back('0);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h5000;
    exp_adr_q.push_back(32'h5000);
    #2;
    chk("midrst_cyc", wbs_cyc_o, 0);
    chk("midrst_ack", wbm_ack_o, 0);
    step();
    wbs_ack_i = 1'b0;
    #2 chk("postrst_p0_first", wbs_adr_o, 32'h5000);
    step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; exp_adr_q.push_back(32'h4008);
    step();
    step(); #2 chk("postrst_p1_next", wbs_adr_o, 32'h4008);
    step();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[1] = CTI_CLASSIC;
    step();

`ifdef WB_PORT_ARBITER_TIMEOUT_EN
    // Hung slave: err on the 16th stb cycle, then drain until the master lets go.
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[2] = 32'h6000; exp_adr_q.push_back(32'h6000);
    for (int s = 1; s < TMO; s++) begin
      step(); #2;
      chk($sformatf("tmo_s%0d_err", s), wbm_err_o, 0);
      chk($sformatf("tmo_s%0d_cyc", s), wbs_cyc_o, 1);
    end
    step(); #2;
    chk("tmo_err_pulse", wbm_err_o, 3'b100);
    chk("tmo_cyc_forced", wbs_cyc_o, 0);
    step(); #2;
    chk("tmo_drain_err", wbm_err_o, 0);
    chk("tmo_drain_cyc", wbs_cyc_o, 0);
    step();
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    step();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; exp_adr_q.push_back(32'h6000);
    step(); #2 chk("tmo_regrant", wbs_cyc_o, 1);
    step();
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    step();
`endif

    step();
    chk("sb_grants_left", 64'(exp_adr_q.size()), 0);
    chk("sb_acks_left", 64'(exp_ack_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
